// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if : request/result bundle between EX-stage control and the
//               multiply/divide sequencer (mdu_ctrl).
//
// Signals
//   MDU_i_Start  request strobe, op/operands valid in the same cycle
//   MDU_i_Op     operation code (3 bits)
//   MDU_i_A      rs operand
//   MDU_i_B      rt operand
//   MDU_i_Flush  kill of the EX instruction, qualifies Start
//   MDU_o_Busy   operation in flight
//   MDU_o_HI     architectural HI
//   MDU_o_LO     architectural LO
//
// Modports
//   master : pipeline side (drives requests, observes Busy/HI/LO)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface mdu_ctrl_if;
    logic        MDU_i_Start;
    logic [2:0]  MDU_i_Op;
    logic [31:0] MDU_i_A;
    logic [31:0] MDU_i_B;
    logic        MDU_i_Flush;
    logic        MDU_o_Busy;
    logic [31:0] MDU_o_HI;
    logic [31:0] MDU_o_LO;

    modport master (
        output MDU_i_Start, MDU_i_Op, MDU_i_A, MDU_i_B, MDU_i_Flush,
        input  MDU_o_Busy, MDU_o_HI, MDU_o_LO
    );

    modport slave (
        input  MDU_i_Start, MDU_i_Op, MDU_i_A, MDU_i_B, MDU_i_Flush,
        output MDU_o_Busy, MDU_o_HI, MDU_o_LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl : multi-cycle multiply/divide sequencer owning HI/LO.
//
// The full result is computed combinationally at accept and parked in a
// pending register pair; a down-counter then models the unit latency, and
// HI/LO are committed on the final RUN edge. Busy is registered.
//
// Ports
//   MDU_i_Clk    clock, rising edge
//   MDU_i_Rst_n  asynchronous active-low reset
//   mdu          mdu_ctrl_if.slave (Start/Op/A/B/Flush in, Busy/HI/LO out)
//
// Parameters
//   MULT_CYCLES  Busy cycles for MULT/MULTU/MADD (1..15)
//   DIV_CYCLES   Busy cycles for DIV/DIVU (1..15)
//
// Configuration macro
//   MDU_MADD_EN  enables op 110 = MADD; when undefined op 110 is a no-op.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       MDU_i_Clk,
    input  logic       MDU_i_Rst_n,
    mdu_ctrl_if.slave  mdu
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [3:0] L_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV_N  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi, r_lo, r_ph, r_pl;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt, w_lo_nxt, w_ph_nxt, w_pl_nxt;

    logic        w_acc, w_op_mul, w_op_div;
    logic [31:0] w_a, w_b;
    logic [63:0] w_prod_s, w_prod_u, w_res;
    logic [31:0] w_b_nz, w_quo_u, w_rem_u;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_mag_nz, w_quo_m, w_rem_m, w_quo_s, w_rem_s;

    assign w_a   = mdu.MDU_i_A;
    assign w_b   = mdu.MDU_i_B;
    assign w_acc = mdu.MDU_i_Start & ~mdu.MDU_i_Flush & (r_state == ST_IDLE);

    assign w_op_div = (mdu.MDU_i_Op == 3'b010) | (mdu.MDU_i_Op == 3'b011);
`ifdef MDU_MADD_EN
    assign w_op_mul = (mdu.MDU_i_Op == 3'b000) | (mdu.MDU_i_Op == 3'b001) |
                      (mdu.MDU_i_Op == 3'b110);
`else
    assign w_op_mul = (mdu.MDU_i_Op == 3'b000) | (mdu.MDU_i_Op == 3'b001);
`endif

    // Products on explicitly extended 64-bit operands
    assign w_prod_s = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};

    // Divisor forced non-zero so the dividers never see 0; the zero case is
    // handled by the result mux keeping HI/LO.
    assign w_b_nz  = (w_b == 32'd0) ? 32'd1 : w_b;
    assign w_quo_u = w_a / w_b_nz;
    assign w_rem_u = w_a % w_b_nz;

    // Signed divide via magnitudes: 0x80000000 has magnitude 0x80000000 as an
    // unsigned value, so 0x80000000 / -1 naturally yields 0x80000000, rem 0.
    assign w_a_neg    = w_a[31];
    assign w_b_neg    = w_b[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - w_a) : w_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - w_b) : w_b;
    assign w_b_mag_nz = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quo_m    = w_a_mag / w_b_mag_nz;
    assign w_rem_m    = w_a_mag % w_b_mag_nz;
    assign w_quo_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_m) : w_quo_m;
    assign w_rem_s    = w_a_neg ? (32'd0 - w_rem_m) : w_rem_m;

    // Pending result select; divide-by-zero keeps current HI/LO
    always_comb begin
        w_res = {r_hi, r_lo};
        case (mdu.MDU_i_Op)
            3'b000:  w_res = w_prod_s;
            3'b001:  w_res = w_prod_u;
            3'b010: begin
                if (w_b == 32'd0) w_res = {r_hi, r_lo};
                else              w_res = {w_rem_s, w_quo_s};
            end
            3'b011: begin
                if (w_b == 32'd0) w_res = {r_hi, r_lo};
                else              w_res = {w_rem_u, w_quo_u};
            end
`ifdef MDU_MADD_EN
            3'b110:  w_res = {r_hi, r_lo} + w_prod_s;
`endif
            default: w_res = {r_hi, r_lo};
        endcase
    end

    // Next-state and datapath update logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_ph_nxt    = r_ph;
        w_pl_nxt    = r_pl;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_op_mul) begin
                        w_state_nxt          = ST_RUN;
                        w_cnt_nxt            = L_MULT_N;
                        {w_ph_nxt, w_pl_nxt} = w_res;
                    end else if (w_op_div) begin
                        w_state_nxt          = ST_RUN;
                        w_cnt_nxt            = L_DIV_N;
                        {w_ph_nxt, w_pl_nxt} = w_res;
                    end else if (mdu.MDU_i_Op == 3'b100) begin
                        w_hi_nxt = w_a;
                    end else if (mdu.MDU_i_Op == 3'b101) begin
                        w_lo_nxt = w_a;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_hi_nxt    = r_ph;
                    w_lo_nxt    = r_pl;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter, HI/LO and pending result registers
    always_ff @(posedge MDU_i_Clk or negedge MDU_i_Rst_n) begin
        if (!MDU_i_Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_ph    <= 32'd0;
            r_pl    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_ph    <= w_ph_nxt;
            r_pl    <= w_pl_nxt;
        end
    end

    assign mdu.MDU_o_Busy = r_busy;
    assign mdu.MDU_o_HI   = r_hi;
    assign mdu.MDU_o_LO   = r_lo;

endmodule
